oflow_conflict_resolve_engine: RTL and testbench

- Parametrised successor conflict-resolve engine for the oflow core.
- After the PE array fills the score board, it scans every (row, PE) entry and maps each candidate ID to a histogram slot through an external ID table RAM.
- For each ID it keeps the minimum-score holder and writes a fallback mark to every losing entry.
- Adds an epoch-tagged table (no per-frame clear), a runtime conflict threshold, slot-overflow detection and a one-time table clear after reset.

---
 rtl/oflow_conflict_resolve_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_oflow_conflict_resolve_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/oflow_conflict_resolve_engine.sv
// Successor conflict-resolve engine: scans the score board, keeps the minimum-score
// holder per candidate ID and marks losers. Optional stats outputs: OFLOW_CR_STATS_EN.
module oflow_conflict_resolve_engine #(
  parameter int ROWS    = 8,
  parameter int PES     = 4,
  parameter int ID_W    = 12,
  parameter int SCORE_W = 16,
  parameter int MAX_IDS = 64,
  parameter int CNT_W   = 7,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW     = (PES > 1) ? $clog2(PES) : 1,
  localparam int SLOT_W = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start,
  input  logic [CNT_W-1:0]   conflict_th,
  output logic               busy,
  output logic               done,
  output logic               th_abort,
  output logic               ovf_abort,
  output logic [RW-1:0]      sb_row,
  output logic [PW-1:0]      sb_pe,
  input  logic [ID_W-1:0]    sb_id,
  input  logic [SCORE_W-1:0] sb_score,
  output logic               sb_wr,
  output logic [RW-1:0]      sb_wr_row,
  output logic [PW-1:0]      sb_wr_pe,
  output logic [ID_W-1:0]    tbl_addr,
  output logic               tbl_we,
  output logic [SLOT_W:0]    tbl_wdata,
  input  logic [SLOT_W:0]    tbl_rdata
`ifdef OFLOW_CR_STATS_EN
  ,
  output logic [SLOT_W:0]              stat_ids,
  output logic [$clog2(ROWS*PES):0]    stat_fallbacks
`endif
);

  localparam int SLOTS = 1 << SLOT_W;
  localparam logic [SLOT_W:0] MAX_U = (SLOT_W+1)'(MAX_IDS);

  // Handshake: start is a level sampled only in CLR_WAIT/IDLE; busy rises on the
  // accepting edge and falls on the edge after the one-cycle done pulse.
  typedef enum logic [2:0] {CLR_WAIT, CLR, IDLE, RD, LKP, RES, UPD} state_t;

  state_t               state;
  logic                 epoch;
  logic                 cleared_flag;
  logic [ID_W-1:0]      clr_addr;
  logic [RW-1:0]        row;
  logic [PW-1:0]        pe;
  logic [ID_W-1:0]      cur_id;
  logic [SCORE_W-1:0]   cur_score;
  logic [SLOT_W-1:0]    slot;
  logic [SLOT_W:0]      slots_used;

  logic [CNT_W-1:0]     cnt       [SLOTS];
  logic [SCORE_W-1:0]   min_score [SLOTS];
  logic [RW-1:0]        min_row   [SLOTS];
  logic [PW-1:0]        min_pe    [SLOTS];
  logic [ID_W-1:0]      slot_id   [SLOTS];

`ifdef OFLOW_CR_STATS_EN
  logic [$clog2(ROWS*PES):0] fb_cnt;
  assign stat_ids       = slots_used;
  assign stat_fallbacks = fb_cnt;
`endif

  logic [SLOT_W-1:0] rd_slot;
  logic              rd_epoch;
  logic              hit;
  logic              full;
  logic              ovf;
  logic              miss_new;
  logic [CNT_W-1:0]  cnt_cur;
  logic [CNT_W-1:0]  cnt_next;
  logic              take;
  logic              better;
  logic              th_hit;
  logic              last;
  logic              clr_last;
  logic              begin_frame;

  assign sb_row = row;
  assign sb_pe  = pe;

  // A single epoch bit aliases entries written two frames back (and the cleared
  // pattern on odd frames), so a hit is confirmed against the slot's own ID.
  always_comb begin
    rd_slot     = tbl_rdata[SLOT_W-1:0];
    rd_epoch    = tbl_rdata[SLOT_W];
    hit         = (rd_epoch == epoch) && ({1'b0, rd_slot} < slots_used) &&
                  (slot_id[rd_slot] == cur_id);
    full        = (slots_used == MAX_U);
    ovf         = (state == RES) && !hit && full;
    miss_new    = (state == RES) && !hit && !full;
    cnt_cur     = cnt[slot];
    cnt_next    = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;
    take        = (cnt_cur == '0);
    better      = (cur_score < min_score[slot]);
    th_hit      = (conflict_th != '0) && (cnt_next >= conflict_th);
    last        = (row == RW'(ROWS-1)) && (pe == PW'(PES-1));
    clr_last    = (state == CLR) && (&clr_addr);
    begin_frame = clr_last || ((state == IDLE) && start && cleared_flag);
  end

  always_comb begin
    done      = 1'b0;
    th_abort  = 1'b0;
    ovf_abort = 1'b0;
    sb_wr     = 1'b0;
    sb_wr_row = '0;
    sb_wr_pe  = '0;
    tbl_addr  = '0;
    tbl_we    = 1'b0;
    tbl_wdata = '0;
    case (state)
      CLR: begin
        tbl_addr  = clr_addr;
        tbl_we    = 1'b1;
        tbl_wdata = {1'b1, {SLOT_W{1'b0}}};
      end
      LKP: begin
        tbl_addr = sb_id;
        done     = (sb_id == '0);
      end
      RES: begin
        tbl_addr  = cur_id;
        tbl_we    = miss_new;
        tbl_wdata = miss_new ? {epoch, slots_used[SLOT_W-1:0]} : '0;
        ovf_abort = ovf;
        done      = ovf;
      end
      UPD: begin
        sb_wr = !take;
        if (!take) begin
          sb_wr_row = better ? min_row[slot] : row;
          sb_wr_pe  = better ? min_pe[slot]  : pe;
        end
        th_abort = th_hit;
        done     = th_hit || last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state        <= CLR_WAIT;
      busy         <= 1'b0;
      epoch        <= 1'b0;
      cleared_flag <= 1'b0;
      clr_addr     <= '0;
      row          <= '0;
      pe           <= '0;
      cur_id       <= '0;
      cur_score    <= '0;
      slot         <= '0;
      slots_used   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        cnt[i]       <= '0;
        min_score[i] <= '1;
        min_row[i]   <= '0;
        min_pe[i]    <= '0;
        slot_id[i]   <= '0;
      end
`ifdef OFLOW_CR_STATS_EN
      fb_cnt <= '0;
`endif
    end else begin
      case (state)
        CLR_WAIT: begin
          if (start) begin
            busy     <= 1'b1;
            clr_addr <= '0;
            state    <= CLR;
          end
        end
        CLR: clr_addr <= clr_addr + 1'b1;
        IDLE: begin
          if (start && !cleared_flag) begin
            busy     <= 1'b1;
            clr_addr <= '0;
            state    <= CLR;
          end
        end
        RD: state <= LKP;
        LKP: begin
          cur_id    <= sb_id;
          cur_score <= sb_score;
          if (sb_id == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RES;
          end
        end
        RES: begin
          if (hit) begin
            slot  <= rd_slot;
            state <= UPD;
          end else if (full) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            slot                                <= slots_used[SLOT_W-1:0];
            slot_id[slots_used[SLOT_W-1:0]]     <= cur_id;
            slots_used                          <= slots_used + 1'b1;
            state                               <= UPD;
          end
        end
        UPD: begin
          cnt[slot] <= cnt_next;
          if (take || better) begin
            min_score[slot] <= cur_score;
            min_row[slot]   <= row;
            min_pe[slot]    <= pe;
          end
`ifdef OFLOW_CR_STATS_EN
          if (!take) fb_cnt <= fb_cnt + 1'b1;
`endif
          if (th_hit || last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (pe == PW'(PES-1)) begin
              pe  <= '0;
              row <= row + 1'b1;
            end else begin
              pe <= pe + 1'b1;
            end
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase

      // The frame that follows the table clear keeps epoch 0, which the cleared
      // pattern is guaranteed to miss.
      if (begin_frame) begin
        busy         <= 1'b1;
        cleared_flag <= 1'b1;
        if (state == IDLE) epoch <= ~epoch;
        row          <= '0;
        pe           <= '0;
        slots_used   <= '0;
        for (int i = 0; i < SLOTS; i++) begin
          cnt[i]       <= '0;
          min_score[i] <= '1;
          min_row[i]   <= '0;
          min_pe[i]    <= '0;
          slot_id[i]   <= '0;
        end
`ifdef OFLOW_CR_STATS_EN
        fb_cnt <= '0;
`endif
        state <= RD;
      end
    end
  end

endmodule

// File: tb/tb_oflow_conflict_resolve_engine.sv
// Directed bench for oflow_conflict_resolve_engine: table of frames plus clear and
// mid-operation reset sequences.
module tb_oflow_conflict_resolve_engine;

  localparam int ROWS    = 2;
  localparam int PES     = 4;
  localparam int ID_W    = 4;
  localparam int SCORE_W = 8;
  localparam int MAX_IDS = 3;
  localparam int CNT_W   = 3;
  localparam int N       = ROWS * PES;

  logic               clk = 1'b0;
  logic               reset_N = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   conflict_th = '0;
  logic               busy, done, th_abort, ovf_abort;
  logic [0:0]         sb_row;
  logic [1:0]         sb_pe;
  logic [ID_W-1:0]    sb_id;
  logic [SCORE_W-1:0] sb_score;
  logic               sb_wr;
  logic [0:0]         sb_wr_row;
  logic [1:0]         sb_wr_pe;
  logic [ID_W-1:0]    tbl_addr;
  logic               tbl_we;
  logic [2:0]         tbl_wdata;
  logic [2:0]         tbl_rdata;
`ifdef OFLOW_CR_STATS_EN
  logic [2:0]         stat_ids;
  logic [3:0]         stat_fallbacks;
`endif

  oflow_conflict_resolve_engine #(
    .ROWS(ROWS), .PES(PES), .ID_W(ID_W), .SCORE_W(SCORE_W),
    .MAX_IDS(MAX_IDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .conflict_th(conflict_th),
    .busy(busy), .done(done), .th_abort(th_abort), .ovf_abort(ovf_abort),
    .sb_row(sb_row), .sb_pe(sb_pe), .sb_id(sb_id), .sb_score(sb_score),
    .sb_wr(sb_wr), .sb_wr_row(sb_wr_row), .sb_wr_pe(sb_wr_pe),
    .tbl_addr(tbl_addr), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
`ifdef OFLOW_CR_STATS_EN
    , .stat_ids(stat_ids), .stat_fallbacks(stat_fallbacks)
`endif
  );

  // Clock / reset.
  always #5 clk = ~clk;

  // Score board and ID table memories, 1-cycle read latency.
  logic [ID_W-1:0]    sbm_id [N];
  logic [SCORE_W-1:0] sbm_sc [N];
  logic [2:0]         tmem   [16];

  always @(posedge clk) begin
    sb_id     <= sbm_id[{sb_row, sb_pe}];
    sb_score  <= sbm_sc[{sb_row, sb_pe}];
    if (tbl_we) tmem[tbl_addr] <= tbl_wdata;
    tbl_rdata <= tmem[tbl_addr];
  end

  typedef struct {
    logic [4*N-1:0] ids;
    logic [8*N-1:0] sc;
    logic [2:0]     th;
    int             nfb;
    logic [3*N-1:0] fb;
    int             nwe;
    logic           thab;
    logic           ovf;
    int             cyc;
    int             st_ids;
    int             st_fb;
  } vec_t;

  vec_t       vecs [6];
  logic [2:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int v, input bit with_clr);
    int cyc, nwe, busy_bad, clr_ok;
    bit got_done;
    logic thab, ovf;
    logic [2:0] code;
    cyc = 0; nwe = 0; busy_bad = 0; clr_ok = 0; got_done = 0; thab = 0; ovf = 0;
    for (int i = 0; i < N; i++) begin
      sbm_id[i] = vecs[v].ids[(N-1-i)*4 +: 4];
      sbm_sc[i] = vecs[v].sc[(N-1-i)*8 +: 8];
    end
    exp_q.delete();
    for (int k = 0; k < vecs[v].nfb; k++) exp_q.push_back(vecs[v].fb[(N-1-k)*3 +: 3]);
    conflict_th = vecs[v].th;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (with_clr) begin
      for (int i = 0; i < 16; i++) begin
        if (tbl_we && tbl_addr == ID_W'(i) && tbl_wdata == 3'b100 && busy && !done) clr_ok++;
        @(negedge clk);
      end
      check("clear_writes", clr_ok, 16);
    end
    for (int t = 0; t < 100 && !got_done; t++) begin
      cyc++;
      if (!busy) busy_bad++;
      if (tbl_we) nwe++;
      if (sb_wr) begin
        code = {sb_wr_row, sb_wr_pe};
        if (exp_q.size() == 0) check("fb_extra", {29'd0, code}, 32'hFFFF_FFFF);
        else check("fb_pos", {29'd0, code}, {29'd0, exp_q.pop_front()});
      end
      if (done) begin
        got_done = 1;
        thab = th_abort;
        ovf  = ovf_abort;
      end else begin
        @(negedge clk);
      end
    end
    check("done_seen", got_done, 1);
    check("done_cycle", cyc, vecs[v].cyc);
    check("th_abort", thab, vecs[v].thab);
    check("ovf_abort", ovf, vecs[v].ovf);
    check("tbl_writes", nwe, vecs[v].nwe);
    check("busy_low_in_frame", busy_bad, 0);
    check("fb_missing", exp_q.size(), 0);
    @(negedge clk);
    check("after_done", {busy, done, th_abort, ovf_abort, sb_wr}, 0);
`ifdef OFLOW_CR_STATS_EN
    check("stat_ids", stat_ids, vecs[v].st_ids);
    check("stat_fallbacks", stat_fallbacks, vecs[v].st_fb);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) tmem[i] = 3'b000;
    for (int i = 0; i < N; i++) begin
      sbm_id[i] = '0;
      sbm_sc[i] = '0;
    end
    vecs[0] = '{ids: {4'd5, 4'd5, 4'd7, 4'd9, 16'd0}, sc: {8'd30, 8'd10, 8'd4, 8'd4, 32'd0},
                th: 3'd0, nfb: 1, fb: {3'd0, 21'd0}, nwe: 3, thab: 1'b0, ovf: 1'b0,
                cyc: 18, st_ids: 3, st_fb: 1};
    vecs[1] = '{ids: {4'd3, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2},
                sc: {8'd8, 8'd5, 8'd5, 8'd9, 8'd1, 8'd8, 8'd5, 8'd7},
                th: 3'd0, nfb: 5, fb: {3'd3, 3'd2, 3'd5, 3'd6, 3'd7, 9'd0}, nwe: 3,
                thab: 1'b0, ovf: 1'b0, cyc: 32, st_ids: 3, st_fb: 5};
    vecs[2] = '{ids: {4'd4, 4'd4, 4'd0, 4'd4, 16'd0}, sc: {8'd3, 8'd2, 8'd0, 8'd1, 32'd0},
                th: 3'd0, nfb: 1, fb: {3'd0, 21'd0}, nwe: 1, thab: 1'b0, ovf: 1'b0,
                cyc: 10, st_ids: 1, st_fb: 1};
    vecs[3] = '{ids: {4'd6, 4'd6, 4'd6, 4'd6, 16'd0}, sc: {8'd9, 8'd8, 8'd7, 8'd1, 32'd0},
                th: 3'd3, nfb: 2, fb: {3'd0, 3'd1, 18'd0}, nwe: 1, thab: 1'b1, ovf: 1'b0,
                cyc: 12, st_ids: 1, st_fb: 2};
    vecs[4] = '{ids: {4'd1, 4'd2, 4'd3, 4'd4, 16'd0}, sc: {8'd1, 8'd1, 8'd1, 8'd1, 32'd0},
                th: 3'd0, nfb: 0, fb: 24'd0, nwe: 3, thab: 1'b0, ovf: 1'b1,
                cyc: 15, st_ids: 3, st_fb: 0};
    vecs[5] = '{ids: {4'd1, 4'd2, 4'd1, 4'd0, 16'd0}, sc: {8'd5, 8'd5, 8'd3, 8'd0, 32'd0},
                th: 3'd0, nfb: 1, fb: {3'd0, 21'd0}, nwe: 2, thab: 1'b0, ovf: 1'b0,
                cyc: 14, st_ids: 2, st_fb: 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, th_abort, ovf_abort, sb_wr, tbl_we, sb_row, sb_pe}, 0);
    reset_N = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, tbl_we, sb_wr}, 0);

    // First start triggers the table clear, then the frame runs.
    run_frame(0, 1'b1);
    for (int v = 1; v < 6; v++) run_frame(v, 1'b0);

    // Reset in the middle of a frame must force a fresh table clear.
    for (int i = 0; i < N; i++) begin
      sbm_id[i] = vecs[1].ids[(N-1-i)*4 +: 4];
      sbm_sc[i] = vecs[1].sc[(N-1-i)*8 +: 8];
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    reset_N = 1'b0;
    #1;
    check("mid_reset_outputs", {busy, done, th_abort, ovf_abort, sb_wr, tbl_we}, 0);
    @(negedge clk) reset_N = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
